fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR controller that shares one multiply-accumulate unit across all taps, replacing the fully parallel tap array. It detects the slow sample-rate `enable` strobe, writes each sample into a circular delay buffer, sequences TAPS MAC cycles against a run-time-loadable coefficient bank, and emits one scaled, flagged result per sample. It sits between the decimating sample source and downstream audio/DSP consumers.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_mac_sequencer_if.sv | 28 ++
 rtl/fir_edge_detect.sv | 21 ++
 rtl/fir_mac_sequencer.sv | 123 ++++++++++++
 tb/tb_fir_mac_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR MAC sequencer.
// Holds the FSM state enum, the accumulator width helper and the reset coefficient bank.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam int DEF_TAPS = 30;

  // Widest sum of TAPS full-width products, so the accumulator can never overflow.
  function automatic int ACC_W(input int width, input int taps);
    return 2 * width + $clog2(taps);
  endfunction

  // Symmetric Q15 low-pass loaded into the coefficient bank at reset.
  localparam int DEF_COEF [DEF_TAPS] = '{
    -42, -71, -69, 0, 160, 376, 540, 480, 0, -820,
    -1600, -1700, 0, 4800, 10200, 10200, 4800, 0, -1700, -1600,
    -820, 0, 480, 540, 376, 160, 0, -69, -71, -42
  };

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample/coefficient/result bundle between the sample source and fir_mac_sequencer.
interface fir_mac_sequencer_if #(
  parameter int WIDTH     = 16,
  parameter int TAPS      = 30,
  parameter int OUT_WIDTH = 16
);
  localparam int AW = $clog2(TAPS);

  logic                        enable;
  logic signed [WIDTH-1:0]     data_in;
  logic                        coef_we;
  logic        [AW-1:0]        coef_addr;
  logic signed [WIDTH-1:0]     coef_data;
  logic                        busy;
  logic                        valid_out;
  logic signed [OUT_WIDTH-1:0] out;
  logic                        overrun;

  modport master (
    output enable, data_in, coef_we, coef_addr, coef_data,
    input  busy, valid_out, out, overrun
  );

  modport slave (
    input  enable, data_in, coef_we, coef_addr, coef_data,
    output busy, valid_out, out, overrun
  );
endinterface

// File: rtl/fir_edge_detect.sv
// Two-flop registration of the slow sample strobe with a one-cycle rising-edge pulse.
module fir_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_edge
);
  logic r_q1, r_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_edge = r_q1 & ~r_q2;
endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC sequenced over TAPS cycles per accepted sample.
// Optional macro FIR_SATURATE_EN clamps the scaled output instead of wrapping it.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int TAPS      = 30,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 15
) (
  input logic                clk,
  input logic                rst,
  fir_mac_sequencer_if.slave bus
);
  localparam int AW   = $clog2(TAPS);
  localparam int FW   = $clog2(TAPS + 1);
  localparam int ACCW = ACC_W(WIDTH, TAPS);

  typedef logic signed [WIDTH-1:0] word_arr_t [TAPS];

  state_t                      r_state, w_next;
  logic                        w_edge, w_busy;
  logic        [AW-1:0]        r_wr_ptr, r_k, w_rd_idx;
  logic        [FW-1:0]        r_fill;
  word_arr_t                   r_buf, r_coef;
  logic signed [ACCW-1:0]      r_acc;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [OUT_WIDTH-1:0] r_out;
  logic                        r_valid, r_overrun;

  function automatic word_arr_t default_bank();
    word_arr_t bank;
    for (int k = 0; k < TAPS; k++) begin
      if (k < DEF_TAPS) bank[AW'(k)] = WIDTH'(DEF_COEF[5'(k)]);
      else              bank[AW'(k)] = '0;
    end
    return bank;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] reduce(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
`ifdef FIR_SATURATE_EN
    localparam logic signed [ACCW-1:0] OUT_MAX = {{(ACCW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] OUT_MIN = {{(ACCW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    s = a >>> OUT_SHIFT;
    if (s > OUT_MAX)      return OUT_MAX[OUT_WIDTH-1:0];
    else if (s < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    else                  return s[OUT_WIDTH-1:0];
`else
    s = a >>> OUT_SHIFT;
    return s[OUT_WIDTH-1:0];
`endif
  endfunction

  fir_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.enable),
    .o_edge (w_edge)
  );

  assign w_busy   = (r_state != IDLE);
  // Newest sample pairs with coef[0]; older samples walk backwards around the ring.
  assign w_rd_idx = (r_wr_ptr >= r_k) ? (r_wr_ptr - r_k) : (AW'(TAPS) + r_wr_ptr - r_k);
  assign w_prod   = r_buf[w_rd_idx] * r_coef[r_k];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_edge) w_next = MAC;
      MAC:     if (r_k == AW'(TAPS - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_k       <= '0;
      r_fill    <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_buf     <= '{default: '0};
      r_coef    <= default_bank();
    end else begin
      r_valid <= 1'b0;
      if (w_edge && w_busy) r_overrun <= 1'b1;
      if (!w_busy && bus.coef_we && ({1'b0, bus.coef_addr} < (AW + 1)'(TAPS)))
        r_coef[bus.coef_addr] <= bus.coef_data;
      case (r_state)
        IDLE: if (w_edge) begin
          r_buf[r_wr_ptr] <= bus.data_in;
          r_acc           <= '0;
          r_k             <= '0;
          if (r_fill != FW'(TAPS)) r_fill <= r_fill + 1'b1;
        end
        MAC: begin
          r_acc <= r_acc + ACCW'(w_prod);
          if (r_k != AW'(TAPS - 1)) r_k <= r_k + 1'b1;
        end
        DONE: begin
          r_out    <= reduce(r_acc);
          r_valid  <= (r_fill == FW'(TAPS));
          r_wr_ptr <= (r_wr_ptr == AW'(TAPS - 1)) ? '0 : r_wr_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.valid_out = r_valid;
  assign bus.out       = r_out;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer at TAPS=4 with Q15 coefficients {16384,8192,4096,2048}.
module tb_fir_mac_sequencer;
  localparam int W  = 16;
  localparam int NT = 4;

  typedef struct {
    logic signed [W-1:0] sample;
    bit                  exp_valid;
    int                  exp_out;
  } vec_t;

  logic clk, rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   base_coef [NT] = '{16384, 8192, 4096, 2048};
  vec_t imp [8];

  fir_mac_sequencer_if #(.WIDTH(W), .TAPS(NT), .OUT_WIDTH(16)) bus ();

  fir_mac_sequencer #(.WIDTH(W), .TAPS(NT), .OUT_WIDTH(16), .OUT_SHIFT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_coef(input int addr, input int data);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'(addr);
    bus.coef_data = 16'(data);
    @(negedge clk);
    bus.coef_we   = 1'b0;
  endtask

  task automatic reset_and_load();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NT; i++) write_coef(i, base_coef[i]);
  endtask

  // One strobe; optional coefficient write at cycle we_cyc (negative = none).
  task automatic run_strobe(input int sample, input int we_cyc, input int we_addr, input int we_data,
                            output bit seen, output int val);
    seen = 1'b0;
    val  = 0;
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.data_in = 16'(sample);
    for (int c = 1; c <= NT + 7; c++) begin
      @(negedge clk);
      if (c == 2) bus.enable = 1'b0;
      if (c == we_cyc) begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'(we_addr);
        bus.coef_data = 16'(we_data);
      end
      if (c == we_cyc + 1) bus.coef_we = 1'b0;
      if (bus.valid_out) begin
        seen = 1'b1;
        val  = int'(bus.out);
      end
    end
  endtask

  initial begin
    bit seen;
    int val;
    int exp_sat;

    imp[0] = '{16'sd0,     1'b0, 0};
    imp[1] = '{16'sd0,     1'b0, 0};
    imp[2] = '{16'sd0,     1'b0, 0};
    imp[3] = '{16'sd16384, 1'b1, 8192};
    imp[4] = '{16'sd0,     1'b1, 4096};
    imp[5] = '{16'sd0,     1'b1, 2048};
    imp[6] = '{16'sd0,     1'b1, 1024};
    imp[7] = '{16'sd0,     1'b1, 0};

    rst = 1'b1;
    bus.enable = 1'b0; bus.data_in = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_valid", int'(bus.valid_out), 0);
    check("rst_out", int'(bus.out), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    for (int i = 0; i < NT; i++) write_coef(i, base_coef[i]);

    for (int i = 0; i < 8; i++) begin
      run_strobe(int'(imp[i].sample), -1, 0, 0, seen, val);
      check($sformatf("imp%0d_valid", i), int'(seen), int'(imp[i].exp_valid));
      check($sformatf("imp%0d_out", i), int'(bus.out), imp[i].exp_out);
    end

    @(negedge clk);
    bus.enable = 1'b1; bus.data_in = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 2) bus.enable = 1'b0;
      check($sformatf("lat_busy_c%0d", c), int'(bus.busy), (c >= 2 && c <= 6) ? 1 : 0);
      check($sformatf("lat_valid_c%0d", c), int'(bus.valid_out), (c == 7) ? 1 : 0);
    end

    run_strobe(16384, 3, 0, 0, seen, val);
    check("cbusy_valid", int'(seen), 1);
    check("cbusy_out", val, 8192);
    for (int i = 0; i < 3; i++) run_strobe(0, -1, 0, 0, seen, val);
    write_coef(0, 0);
    run_strobe(16384, -1, 0, 0, seen, val);
    check("cidle_valid", int'(seen), 1);
    check("cidle_out0", val, 0);
    run_strobe(0, -1, 0, 0, seen, val);
    check("cidle_out1", val, 4096);

    reset_and_load();
    @(negedge clk);
    bus.enable = 1'b1; bus.data_in = 16'sd1000;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) bus.enable = 1'b0;
      if (c == 3) begin bus.enable = 1'b1; bus.data_in = 16'sd5000; end
      if (c == 5) bus.enable = 1'b0;
    end
    check("ovr_flag", int'(bus.overrun), 1);
    check("ovr_first_out", int'(bus.out), 500);
    run_strobe(0, -1, 0, 0, seen, val);
    check("ovr_s2_valid", int'(seen), 0);
    run_strobe(0, -1, 0, 0, seen, val);
    check("ovr_s3_valid", int'(seen), 0);
    run_strobe(0, -1, 0, 0, seen, val);
    check("ovr_s4_valid", int'(seen), 1);
    check("ovr_s4_out", val, 62);
    check("ovr_sticky", int'(bus.overrun), 1);

    @(negedge clk);
    bus.enable = 1'b1; bus.data_in = 16'sd16384;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) bus.enable = 1'b0;
    end
    check("mid_pre_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("mid_busy", int'(bus.busy), 0);
    check("mid_valid", int'(bus.valid_out), 0);
    check("mid_out", int'(bus.out), 0);
    check("mid_overrun", int'(bus.overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NT; i++) write_coef(i, base_coef[i]);
    for (int i = 0; i < 3; i++) begin
      run_strobe(16384, -1, 0, 0, seen, val);
      check($sformatf("mid_post%0d_valid", i), int'(seen), 0);
    end

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NT; i++) write_coef(i, 32767);
`ifdef FIR_SATURATE_EN
    exp_sat = 32767;
`else
    exp_sat = -8;
`endif
    for (int i = 0; i < NT; i++) run_strobe(32767, -1, 0, 0, seen, val);
    check("sat_valid", int'(seen), 1);
    check("sat_out", val, exp_sat);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
